// File: rtl/alu_seq_pkg.sv
// Opcode map, FSM state encoding and opcode-class helpers shared by the
// sequential ALU and its multiply/divide engine.
package alu_seq_pkg;

  localparam int unsigned OpAdd    = 0;
  localparam int unsigned OpSub    = 1;
  localparam int unsigned OpAnd    = 2;
  localparam int unsigned OpOr     = 3;
  localparam int unsigned OpXor    = 4;
  localparam int unsigned OpPas    = 5;
  localparam int unsigned OpLt     = 6;
  localparam int unsigned OpLtu    = 7;
  localparam int unsigned OpGe     = 8;
  localparam int unsigned OpGeu    = 9;
  localparam int unsigned OpEq     = 10;
  localparam int unsigned OpNe     = 11;
  localparam int unsigned OpMul    = 16;
  localparam int unsigned OpMulh   = 17;
  localparam int unsigned OpMulhsu = 18;
  localparam int unsigned OpMulhu  = 19;
  localparam int unsigned OpDiv    = 20;
  localparam int unsigned OpDivu   = 21;
  localparam int unsigned OpRem    = 22;
  localparam int unsigned OpRemu   = 23;

  typedef enum logic [1:0] {
    AluIdle,
    AluBusy,
    AluDone
  } alu_state_e;

  function automatic logic is_mul_op(input int unsigned op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpMulhu};
  endfunction

  function automatic logic is_div_op(input int unsigned op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) engine. One step per cycle for
// WIDTH cycles; done is asserted during the last step with the sign-fixed result.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic             want_hi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]        cnt_q;
  logic                 is_div_q, want_hi_q, neg_q, rneg_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q;
  logic [WIDTH-1:0]     shreg_q, dvsr_q, rem_q;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   mul_sum, prod;
  logic [WIDTH:0]       rem_sh, rem_sub;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_nx, quo_nx, quo_fix, rem_fix;

  assign a_neg = a_signed & a[WIDTH-1];
  assign b_neg = b_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign done  = (cnt_q == CW'(1));

  always_comb begin
    mul_sum = acc_q + (shreg_q[0] ? mcand_q : '0);
    // Only the low WIDTH multiplier bits are stepped; a negative multiplier
    // needs a_ext << WIDTH taken off, which is mcand << 1 on the last step.
    prod    = mul_sum - (neg_q ? {mcand_q[2*WIDTH-2:0], 1'b0} : '0);
    rem_sh  = {rem_q, shreg_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvsr_q};
    q_bit   = ~rem_sub[WIDTH];
    rem_nx  = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx  = {shreg_q[WIDTH-2:0], q_bit};
    quo_fix = neg_q ? -quo_nx : quo_nx;
    rem_fix = rneg_q ? -rem_nx : rem_nx;
    if (is_div_q) begin
      result = want_hi_q ? rem_fix : quo_fix;
    end else begin
      result = want_hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      want_hi_q <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      shreg_q   <= '0;
      dvsr_q    <= '0;
      rem_q     <= '0;
    end else if (start) begin
      cnt_q     <= CW'(WIDTH);
      is_div_q  <= is_div;
      want_hi_q <= want_hi;
      acc_q     <= '0;
      rem_q     <= '0;
      if (is_div) begin
        shreg_q <= a_mag;
        dvsr_q  <= b_mag;
        mcand_q <= '0;
        neg_q   <= a_neg ^ b_neg;
        rneg_q  <= a_neg;
      end else begin
        shreg_q <= b;
        dvsr_q  <= '0;
        mcand_q <= a_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        neg_q   <= b_neg;
        rneg_q  <= 1'b0;
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      if (is_div_q) begin
        rem_q   <= rem_nx;
        shreg_q <= quo_nx;
      end else begin
        acc_q   <= mul_sum;
        mcand_q <= mcand_q << 1;
        shreg_q <= shreg_q >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with RV32M multiply/divide and valid/ready handshakes on both sides.
// Define ALU_SEQ_FAST_MUL_EN for a single-cycle combinational MUL family.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_e       state_q;
  logic [31:0]      op;
  logic             accept, is_mul, is_div, a_signed, b_signed, want_hi;
  logic             div_by_zero, div_ovf, div_special, use_iter;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sub, single_y, div_spec_y, mdu_y;
  logic             ovf, lt, ltu, zero, mdu_done;

  assign op       = 32'(in_op);
  assign in_ready = (state_q == AluIdle) || ((state_q == AluDone) && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == AluBusy);

  assign is_mul   = is_mul_op(op);
  assign is_div   = is_div_op(op);
  assign a_signed = op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  assign b_signed = op inside {OpMul, OpMulh, OpDiv, OpRem};
  assign want_hi  = op inside {OpMulh, OpMulhsu, OpMulhu, OpRem, OpRemu};

  // Legacy flag rules on a (WIDTH+1)-bit subtract.
  assign diff = {1'b0, in_a} - {1'b0, in_b};
  assign sub  = diff[WIDTH-1:0];
  assign ltu  = diff[WIDTH];
  assign ovf  = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (in_a[WIDTH-1] ^ sub[WIDTH-1]);
  assign lt   = sub[WIDTH-1] ^ ovf;
  assign zero = (sub == '0);

  assign div_by_zero = (in_b == '0);
  assign div_ovf     = b_signed && (in_a == MinVal) && (in_b == '1);
  assign div_special = div_by_zero || div_ovf;

  always_comb begin
    div_spec_y = '0;
    if (div_by_zero) begin
      div_spec_y = want_hi ? in_a : '1;
    end else if (div_ovf) begin
      div_spec_y = want_hi ? '0 : in_a;
    end
  end

`ifdef ALU_SEQ_FAST_MUL_EN
  logic [2*WIDTH-1:0] a_ext, b_ext, fast_prod;
  assign a_ext     = a_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
  assign b_ext     = b_signed ? {{WIDTH{in_b[WIDTH-1]}}, in_b} : {{WIDTH{1'b0}}, in_b};
  assign fast_prod = a_ext * b_ext;
  assign use_iter  = is_div && !div_special;
`else
  assign use_iter  = is_mul || (is_div && !div_special);
`endif

  always_comb begin
    single_y = sub;
    case (op)
      OpAdd:   single_y = in_a + in_b;
      OpAnd:   single_y = in_a & in_b;
      OpOr:    single_y = in_a | in_b;
      OpXor:   single_y = in_a ^ in_b;
      OpPas:   single_y = in_a;
      OpLt:    single_y = {{(WIDTH-1){1'b0}}, lt};
      OpLtu:   single_y = {{(WIDTH-1){1'b0}}, ltu};
      OpGe:    single_y = {{(WIDTH-1){1'b0}}, ~lt};
      OpGeu:   single_y = {{(WIDTH-1){1'b0}}, ~ltu};
      OpEq:    single_y = {{(WIDTH-1){1'b0}}, zero};
      OpNe:    single_y = {{(WIDTH-1){1'b0}}, ~zero};
      OpDiv, OpDivu, OpRem, OpRemu: single_y = div_spec_y;
`ifdef ALU_SEQ_FAST_MUL_EN
      OpMul:   single_y = fast_prod[WIDTH-1:0];
      OpMulh, OpMulhsu, OpMulhu: single_y = fast_prod[2*WIDTH-1:WIDTH];
`endif
      default: single_y = sub;
    endcase
  end

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && use_iter),
    .is_div  (is_div),
    .a_signed(a_signed),
    .b_signed(b_signed),
    .want_hi (want_hi),
    .a       (in_a),
    .b       (in_b),
    .done    (mdu_done),
    .result  (mdu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= AluIdle;
      out_valid <= 1'b0;
      out_y     <= '0;
    end else begin
      case (state_q)
        AluBusy: begin
          if (mdu_done) begin
            state_q   <= AluDone;
            out_valid <= 1'b1;
            out_y     <= mdu_y;
          end
        end
        default: begin
          // Idle, or Done with the result being taken this cycle.
          if (in_ready) begin
            if (accept && use_iter) begin
              state_q   <= AluBusy;
              out_valid <= 1'b0;
            end else if (accept) begin
              state_q   <= AluDone;
              out_valid <= 1'b1;
              out_y     <= single_y;
            end else begin
              state_q   <= AluIdle;
              out_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are queued at accept and
// compared (value and latency) when the result is taken.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_y;
  logic        busy;

  alu_seq #(
    .WIDTH(32),
    .OPW  (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    int          acc;
    int          lat;
    int          op;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_err = 0;
  int   n_chk = 0;
  int   busy_cycles = 0;
  int   last_acc = 0;

  localparam logic [31:0] Min = 32'h8000_0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      OpAdd:    return a + b;
      OpSub:    return a - b;
      OpAnd:    return a & b;
      OpOr:     return a | b;
      OpXor:    return a ^ b;
      OpPas:    return a;
      OpLt:     return {31'h0, $signed(a) < $signed(b)};
      OpLtu:    return {31'h0, a < b};
      OpGe:     return {31'h0, $signed(a) >= $signed(b)};
      OpGeu:    return {31'h0, a >= b};
      OpEq:     return {31'h0, a == b};
      OpNe:     return {31'h0, a != b};
      OpMul:    begin p = sa * sb; return p[31:0]; end
      OpMulh:   begin p = sa * sb; return p[63:32]; end
      OpMulhsu: begin p = sa * $signed(ub); return p[63:32]; end
      OpMulhu:  begin p = ua * ub; return p[63:32]; end
      OpDiv:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == Min && b == 32'hFFFF_FFFF) return Min;
        return $signed(a) / $signed(b);
      end
      OpDivu:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OpRem:    begin
        if (b == 0) return a;
        if (a == Min && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      OpRemu:   return (b == 0) ? a : a % b;
      default:  return a - b;
    endcase
  endfunction

  function automatic int model_lat(input int op, input logic [31:0] a, input logic [31:0] b);
    if (op >= OpMul && op <= OpMulhu) begin
`ifdef ALU_SEQ_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if (op >= OpDiv && op <= OpRemu) begin
      if (b == 0) return 1;
      if ((op == OpDiv || op == OpRem) && a == Min && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge with in_valid low.
  task automatic send(input int op, input logic [31:0] a, input logic [31:0] b,
                      input bit chk_lat);
    exp_t e;
    int   n;
    in_op    = 5'(op);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b0;
      last_acc = -1;
      return;
    end
    e.y   = model(op, a, b);
    e.acc = cyc;
    e.lat = chk_lat ? model_lat(op, a, b) : -1;
    e.op  = op;
    sbq.push_back(e);
    last_acc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cycles <= busy_cycles + 1;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("spurious_out", {31'h0, out_valid}, 32'h0);
      end else begin
        e = sbq.pop_front();
        check($sformatf("y_op%0d", e.op), out_y, e.y);
        if (e.lat >= 0) check($sformatf("lat_op%0d", e.op), cyc - e.acc, e.lat);
      end
    end
  end

  initial begin
    int   b0, rel, n;
    logic seen;
    int   rops[12];

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_y", out_y, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops, then the rest of the compare/logic set.
    send(OpAdd, 32'hFFFF_FFFF, 32'h1, 1'b1);
    send(OpLt, Min, 32'h1, 1'b1);
    send(OpSub, 32'd5, 32'd9, 1'b1);
    send(OpAnd, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1);
    send(OpOr, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1);
    send(OpXor, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1);
    send(OpPas, 32'hDEAD_BEEF, 32'h1, 1'b1);
    send(OpLtu, Min, 32'h1, 1'b1);
    send(OpGe, 32'h7FFF_FFFF, Min, 1'b1);
    send(OpGeu, 32'h7FFF_FFFF, Min, 1'b1);
    send(OpEq, 32'h1234, 32'h1234, 1'b1);
    send(OpNe, 32'h1234, 32'h1234, 1'b1);
    send(13, 32'd10, 32'd3, 1'b1);
    send(31, 32'd3, 32'd10, 1'b1);
    drain();

    b0 = busy_cycles;
    send(OpMulh, Min, Min, 1'b1);
    send(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(OpMul, 32'hFFFF_FFF9, 32'd3, 1'b1);
    send(OpMulhsu, 32'hFFFF_FFFF, 32'd2, 1'b1);
    send(OpMulh, 32'd3, 32'hFFFF_FFFE, 1'b1);
    drain();
`ifdef ALU_SEQ_FAST_MUL_EN
    check("mul_busy_seen", {31'h0, busy_cycles != b0}, 32'h0);
`else
    check("mul_busy_seen", {31'h0, busy_cycles != b0}, 32'h1);
`endif

    send(OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b1);
    send(OpRem, 32'hFFFF_FFF9, 32'd2, 1'b1);
    send(OpDivu, 32'd100, 32'd0, 1'b1);
    send(OpRemu, 32'd100, 32'd0, 1'b1);
    send(OpRem, 32'hFFFF_FFF9, 32'd0, 1'b1);
    send(OpDiv, Min, 32'hFFFF_FFFF, 1'b1);
    send(OpRem, Min, 32'hFFFF_FFFF, 1'b1);
    send(OpDivu, 32'hFFFF_FFFF, 32'd3, 1'b1);
    send(OpRemu, 32'hFFFF_FFFF, 32'd7, 1'b1);
    send(OpDiv, 32'd7, 32'hFFFF_FFFE, 1'b1);
    drain();

    // Backpressure: result held 10 cycles; a pending op is taken on release.
    out_ready = 1'b0;
    send(OpDivu, 32'd1000, 32'd7, 1'b0);
    rel = -2;
    fork
      send(OpAdd, 32'd5, 32'd6, 1'b1);
      begin
        n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("bp_valid", {31'h0, out_valid}, 32'h1);
        repeat (10) begin
          check("bp_y", out_y, 32'd142);
          check("bp_in_ready", {31'h0, in_ready}, 32'h0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        rel = cyc;
        out_ready = 1'b1;
      end
    join
    check("bp_same_cycle", last_acc, rel);
    drain();

    // Reset during a divide discards it.
    in_op    = 5'(OpDiv);
    in_a     = 32'hFFFF_FFF9;
    in_b     = 32'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    seen = 1'b0;
    repeat (35) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_result", {31'h0, seen}, 32'h0);
    @(posedge clk);
    #1;
    send(OpAdd, 32'd3, 32'd4, 1'b1);
    drain();

    rops = '{OpAdd, OpSub, OpLt, OpGeu, OpMul, OpMulh, OpMulhsu, OpMulhu,
             OpDiv, OpDivu, OpRem, OpRemu};
    for (int i = 0; i < 24; i++) begin
      send(rops[$urandom_range(0, 11)], $urandom(),
           (i % 4 == 0) ? 32'($urandom_range(0, 2)) : $urandom(), 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational ALU in the execute stage.
- Keeps all existing ALU/compare opcodes from `format.vh` at WIDTH bits.
- Adds RV32M multiply/divide (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), implemented by an iterative shift-add / restoring-divide engine.
- Sits between decode/issue and writeback, with a valid/ready handshake on both sides so the pipeline can stall during multi-cycle ops.

Parameters:
- WIDTH, 32, operand and result width (>=8).
- OPW, 5, opcode width; matches the existing `format.vh` opcode field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation this cycle
- in_a  in  WIDTH  operand A (rs1)
- in_b  in  WIDTH  operand B (rs2/imm)
- in_op  in  OPW  opcode (`format.vh` codes plus new M-extension codes)
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes the result
- out_y  out  WIDTH  result; compare ops give 0/1 zero-extended
- busy  out  1  high while in BUSY state

Behaviour:
- Reset (rst=1 at a clk edge):
  - State -> IDLE; out_valid=0; out_y=0; busy=0; step counter=0.
  - Any in-flight operation is discarded and produces no result.
  - in_ready=1 from the first cycle after reset.
- States: IDLE, BUSY, DONE.
- Accept rule: operands, opcode and signedness are captured when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - This allows back-to-back single-cycle ops at full throughput.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, PAS, LT, LTU, GE, GEU, EQ, NE):
  - Result computed with the existing flag rules: overflow from sign bits; lt = sign^overflow; ltu = borrow out of the (WIDTH+1)-bit subtract; zero = (A-B)==0.
  - Result registered at the accept edge; -> DONE; out_valid=1 the next cycle (latency 1).
- MUL family:
  - Operands are sign- or zero-extended to 2*WIDTH per opcode, then -> BUSY with counter=WIDTH.
  - One shift-add step per cycle; after WIDTH steps -> DONE.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
  - Latency WIDTH+1 cycles from accept to out_valid.
- DIV family:
  - Divide on magnitudes; the signs of quotient and remainder are fixed up in the final step.
  - Latency WIDTH+1 cycles.
  - Remainder takes the dividend's sign.
- Division special cases (decided at accept, -> DONE with latency 1):
  - Divide by zero: DIV/DIVU = all-ones; REM/REMU = dividend.
  - Signed overflow (A = MIN, B = -1): DIV = MIN; REM = 0.
- DONE: out_y and out_valid are held stable until out_ready.
  - On out_ready: if a new op is accepted in the same cycle, go to its state per the rules above; else -> IDLE, out_valid=0.
- Undefined opcodes: treated as SUB (matches the legacy default).
- Inputs offered while BUSY: ignored (in_ready=0). No abort except rst.
- All arithmetic is modulo 2^WIDTH except the internal 2*WIDTH product and the WIDTH+1 remainder accumulator.

Optional Feature:
- Macro: ALU_SEQ_FAST_MUL_EN.
- Defined: the MUL family uses a single-cycle 2*WIDTH combinational multiplier; latency 1, never enters BUSY.
- Undefined: the iterative engine is used (latency WIDTH+1).
- The DIV family is iterative in both builds.
- Results must be bit-identical in both builds.

Decomposition:
- Shared header `format.vh`:
  - New opcode macros IMUL, IMULH, IMULHSU, IMULHU, IDIV, IDIVU, IREM, IREMU.
  - State encodings ALU_IDLE/ALU_BUSY/ALU_DONE.
- Sub-module `muldiv_iter`:
  - Holds the iterative engine: accumulator, shift registers, counter, sign fix-up.
  - Start/done interface.
  - The top level keeps the handshake FSM and the single-cycle datapath.

Test Plan:
- Reset mid-DIV (rst at cycle 5 of 33) -> out_valid stays 0; in_ready=1 next cycle; next ADD 3+4 returns out_y=7 at latency 1.
- Back-to-back with out_ready=1: ADD 0xFFFFFFFF+1, then LT 0x80000000,1 -> out_y=0 then 1 on consecutive cycles, no bubbles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000 after 33 cycles; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL -7 x 3 -> 0xFFFFFFEB.
- DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF, latency 1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- Backpressure: out_ready=0 for 10 cycles after a DIVU result -> out_y stable, in_ready=0, new in_valid ignored; release -> op accepted in the same cycle.
- Build with ALU_SEQ_FAST_MUL_EN and rerun the MUL vectors -> identical results, latency 1, busy never asserted.
